// File: rtl/uart_rx.sv
// uart_rx - 8N1 asynchronous serial receiver with valid/ready output.
//
// Oversamples the synchronised line at OVERSAMPLE ticks per bit, centres on
// the start bit, rejects short low glitches, and presents each good byte in a
// holding register until the consumer takes it.
//
// Optional build macro: UART_RX_PARITY_EN adds one even-parity bit after the
// data bits and a parity_err pulse output.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   rx         serial line, idle high, asynchronous to clk
//   data       received byte, stable while valid=1
//   valid      byte available in holding register
//   ready      consumer takes the byte on valid && ready
//   frame_err  one-cycle pulse, stop bit sampled low
//   overrun    one-cycle pulse, good byte dropped because valid was held
//   parity_err one-cycle pulse, parity mismatch (UART_RX_PARITY_EN only)
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | line idle, looking for a low sample on a tick
// S_START   | qualifying start bit, glitch check at mid-bit
// S_DATA    | shifting in 8 data bits, LSB first
// S_PARITY  | sampling the even-parity bit (UART_RX_PARITY_EN only)
// S_STOP    | sampling stop bit at mid-bit, delivering the byte
// S_WAIT    | after a framing error, waiting for the line to go high
`timescale 1ns/1ps

module uart_rx #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       overrun
);

  localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SC_W  = $clog2(OVERSAMPLE);

  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(DIV - 1);
  localparam logic [SC_W-1:0]  SC_MID     = SC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SC_W-1:0]  SC_LAST    = SC_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT
  } state_t;

  state_t           state;
  logic             rx_meta, line;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [SC_W-1:0]  scnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             par_ok;

  // Two-flop synchroniser, preset to the idle level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      line    <= 1'b1;
    end else begin
      rx_meta <= rx;
      line    <= rx_meta;
    end
  end

  // Tick divider: down-counter, tick on terminal count then reload.
  assign tick = (div_cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= DIV_RELOAD;
    end else begin
      div_cnt <= div_cnt - 1'b1;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  // Even parity: data bits plus parity bit must XOR to zero.
  assign par_ok = ~(^shreg ^ par_bit);
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      scnt      <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (valid && ready) valid <= 1'b0;

      if (tick) begin
        case (state)
          S_IDLE: begin
            if (!line) begin
              state <= S_START;
              scnt  <= '0;
            end
          end
          S_START: begin
            if (scnt == SC_MID && line) begin
              state <= S_IDLE;
            end else if (scnt == SC_LAST) begin
              state   <= S_DATA;
              scnt    <= '0;
              bit_idx <= '0;
            end else begin
              scnt <= scnt + 1'b1;
            end
          end
          S_DATA: begin
            if (scnt == SC_MID) shreg <= {line, shreg[7:1]};
            if (scnt == SC_LAST) begin
              scnt <= '0;
              if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state <= S_PARITY;
`else
                state <= S_STOP;
`endif
              end else begin
                bit_idx <= bit_idx + 1'b1;
              end
            end else begin
              scnt <= scnt + 1'b1;
            end
          end
`ifdef UART_RX_PARITY_EN
          S_PARITY: begin
            if (scnt == SC_MID) par_bit <= line;
            if (scnt == SC_LAST) begin
              scnt  <= '0;
              state <= S_STOP;
            end else begin
              scnt <= scnt + 1'b1;
            end
          end
`endif
          S_STOP: begin
            if (scnt == SC_MID) begin
              if (!line) begin
                frame_err <= 1'b1;
                state     <= S_WAIT;
              end else begin
                // Return at mid-stop so a back-to-back start edge is caught.
                state <= S_IDLE;
                if (par_ok) begin
                  // A byte accepted this same clk frees the holding register.
                  if (valid && !ready) begin
                    overrun <= 1'b1;
                  end else begin
                    data  <= shreg;
                    valid <= 1'b1;
                  end
                end
`ifdef UART_RX_PARITY_EN
                else begin
                  parity_err <= 1'b1;
                end
`endif
              end
            end else begin
              scnt <= scnt + 1'b1;
            end
          end
          S_WAIT: begin
            if (line) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx - scoreboard bench for uart_rx.
//
// Runs the receiver at a scaled-down bit rate (4 clk per tick, 64 clk per
// bit). The stimulus side computes each frame's expected outcome from the
// line protocol and queues expected bytes and flag counts; a monitor on the
// falling edge pops and compares whenever a byte is handed over.
`timescale 1ns/1ps

module tb_uart_rx;

  localparam int CF   = 640;
  localparam int BD   = 10;
  localparam int OS   = 16;
  localparam int DIV  = CF / (BD * OS);
  localparam int BIT  = DIV * OS;
  localparam int LAT  = 2 * DIV + 3 + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] data;
  logic       valid, frame_err, overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx #(.CLK_FREQ(CF), .BAUD(BD), .OVERSAMPLE(OS)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  int         fe_seen = 0, ov_seen = 0, pe_seen = 0;
  int         fe_exp = 0, ov_exp = 0, pe_exp = 0;
  logic [7:0] prev_data;
  logic       prev_hold = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: counts flag pulses, checks handed-over bytes and holding stability.
  always @(negedge clk) begin
    if (!rst) begin
      prev_hold = 1'b0;
    end else begin
      if (frame_err) fe_seen++;
      if (overrun) ov_seen++;
`ifdef UART_RX_PARITY_EN
      if (parity_err) pe_seen++;
`endif
      if (prev_hold) begin
        n_checks++;
        if (data !== prev_data) begin
          n_fail++;
          $display("FAIL data_stable: got %h expected %h", data, prev_data);
        end
      end
      if (valid && ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_byte: got %h expected none", data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (data !== e) begin
            n_fail++;
            $display("FAIL rx_byte: got %h expected %h", data, e);
          end
        end
      end
      prev_hold = valid && !ready;
      prev_data = data;
    end
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    clks(BIT);
  endtask

  // Sends one frame; when chk_lat is set, the byte must have been handed
  // over within the latency bound after the stop bit's mid-point.
  task automatic send_frame(input logic [7:0] b, input logic stop_v,
                            input logic par_flip, input logic chk_lat);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^b ^ par_flip);
`endif
    rx = stop_v;
    clks(BIT / 2 + LAT);
    if (chk_lat) check("latency_queue_empty", exp_q.size(), 0);
    clks(BIT - BIT / 2 - LAT);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clks(4);
    check("reset_data", data, 8'h00);
    check("reset_valid", valid, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_overrun", overrun, 0);
    rst = 1'b1;
    clks(2 * BIT);

    // Clean frame.
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
    clks(BIT);

    // Short low glitch.
    rx = 1'b0;
    clks(4 * DIV);
    rx = 1'b1;
    clks(2 * BIT);
    check("glitch_valid", valid, 0);
    check("glitch_frame_err", fe_seen, fe_exp);

    // Bad stop bit followed by a long break, then recovery.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    fe_exp++;
    rx = 1'b0;
    clks(5 * BIT);
    rx = 1'b1;
    clks(2 * BIT);
    check("break_frame_err_count", fe_seen, fe_exp);
    check("break_valid", valid, 0);
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, 1'b0, 1'b1);
    clks(BIT);

    // Overrun with consumer stalled.
    ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    ov_exp++;
    clks(BIT);
    check("overrun_data_held", data, 8'h11);
    check("overrun_valid_held", valid, 1);
    check("overrun_count", ov_seen, ov_exp);
    ready = 1'b1;
    clks(3);
    check("overrun_valid_drop", valid, 0);
    check("overrun_data_after", data, 8'h11);
    check("overrun_queue_empty", exp_q.size(), 0);

    // Reset in the middle of data bit 4.
    fork
      send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
      begin
        clks(5 * BIT + BIT / 2);
        rst = 1'b0;
        clks(1);
        check("midreset_data", data, 8'h00);
        check("midreset_valid", valid, 0);
        clks(2);
        rst = 1'b1;
      end
    join
    clks(BIT);
    check("midreset_no_output", valid, 0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, 1'b0, 1'b1);
    clks(BIT);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones, so the even-parity bit is 1; sending 0 is a mismatch.
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    pe_exp++;
    clks(BIT);
    check("parity_err_count", pe_seen, pe_exp);
    check("parity_bad_valid", valid, 0);
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b0, 1'b1);
    clks(BIT);
    check("parity_good_count", pe_seen, pe_exp);
`endif

    // Randomised frames with occasional bad stop bits and parity flips.
    for (int k = 0; k < 30; k++) begin
      logic [7:0] b;
      logic       good_stop, flip;
      int         gap;
      b         = 8'($urandom);
      good_stop = ($urandom_range(0, 7) != 0);
      flip      = 1'b0;
`ifdef UART_RX_PARITY_EN
      flip      = ($urandom_range(0, 7) == 0);
`endif
      if (!good_stop) fe_exp++;
      else if (flip) pe_exp++;
      else exp_q.push_back(b);
      send_frame(b, good_stop, flip, good_stop && !flip);
      gap = $urandom_range(0, 2);
      if (!good_stop && gap == 0) gap = 1;
      rx = 1'b1;
      clks(gap * BIT);
    end
    clks(2 * BIT);

    check("final_frame_err_count", fe_seen, fe_exp);
    check("final_overrun_count", ov_seen, ov_exp);
    check("final_parity_err_count", pe_seen, pe_exp);
    check("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 asynchronous serial receiver: the receive-side counterpart of the team's UART transmitter.
- Consumes the serial line (e.g. a transmitter's tx pin or the board RX pin) and produces one byte at a time.
- Output uses a valid/ready handshake toward the command parser.
- Oversamples the line, rejects glitch start bits, and flags framing errors and overruns.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 9600, line bit rate.
- OVERSAMPLE, 16, sample ticks per bit. Must be even and >= 8.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- rx  input  1  serial line, idle high, asynchronous to clk.
- data  output  8  received byte; stable while valid=1.
- valid  output  1  byte available in the holding register.
- ready  input  1  consumer accepts the byte when valid && ready on a clk edge.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: new byte completed while valid was still 1.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; tick divider cleared; partial frame discarded.
  - data=8'h00, valid=0, frame_err=0, overrun=0.
  - Both synchroniser flops are set to 1 (line idle).
- Synchroniser: rx passes through 2 flops before any use. All references to "line" below mean the synchronised value.
- Tick generator:
  - Free-running counter; asserts tick for one clk every DIV = CLK_FREQ/(BAUD*OVERSAMPLE) cycles, using integer division.
  - At the defaults DIV=651, so one bit = 10416 clk.
- Sample counter: scnt counts ticks 0..OVERSAMPLE-1 within each bit.
- IDLE:
  - On a tick with line=0, go to START with scnt=0.
- START:
  - At scnt=OVERSAMPLE/2-1 (mid-bit): if line=1, the start is a glitch; return to IDLE with no flags.
  - Otherwise, at scnt=OVERSAMPLE-1, go to DATA with bit index 0.
- DATA:
  - At mid-bit, shift the line value in, LSB first.
  - After bit 7's last tick, go to STOP.
- STOP, at mid-bit:
  - Line=1: frame is good. If valid=0, load data and set valid=1 on the next clk. If valid=1, drop the new byte, pulse overrun, and leave data unchanged.
  - Line=0: pulse frame_err, discard the byte, and go to WAIT_IDLE.
  - Good frames return to IDLE at mid-stop, which allows back-to-back frames.
- WAIT_IDLE: stay until line=1 is seen on a tick, then go to IDLE. A break condition produces exactly one frame_err.
- Handshake:
  - valid clears on the clk where valid && ready.
  - If a byte is accepted on the same clk that a new good frame completes, accept the old byte and load the new one; valid stays 1 and there is no overrun.
- Latency: valid rises within 2 ticks + 3 clk after the mid-point of the stop bit on the rx pin.
- Data width: fixed at 8. The bit index is 3 bits and does not wrap inside a frame.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - A PARITY state sits between DATA and STOP and samples one even-parity bit at mid-bit.
  - A mismatch pulses an extra output parity_err (1 bit, reset 0) at mid-stop and discards the byte.
  - A stop-bit failure still takes priority: frame_err is pulsed and parity_err is not.
- Undefined: no PARITY state and no parity_err port; the frame is strictly 8N1.

Test Plan:
- Clean frame 0xA5 (start, 1,0,1,0,0,1,0,1 LSB first, stop) at 10416 clk/bit, ready=1 -> valid pulses 1 clk with data=8'hA5; frame_err=0, overrun=0.
- Low glitch on rx for 2000 clk, then line idle -> no state change past START, valid=0, no flags.
- Frame 0x3C with the stop bit driven 0, then rx held low 5 bit times -> exactly one frame_err pulse, valid=0. After rx returns high, frame 0x55 -> data=8'h55.
- ready=0, two back-to-back frames 0x11 then 0x22 -> data=8'h11 held, one overrun pulse at the second stop bit. Assert ready -> valid drops, data stays 8'h11.
- rst driven low in the middle of bit 4 of frame 0xFF, released, then frame 0x81 sent -> no output for the aborted frame; data=8'h81 received.
- With UART_RX_PARITY_EN, frame 0x07 with parity bit 0 -> parity_err pulses once, valid=0. Frame 0x07 with parity bit 1 -> data=8'h07, no parity_err.
